// File: rtl/multi_one_shot_pkg.sv
// multi_one_shot_pkg: shared constants for the multi-channel one-shot.
//   COUNT_W_DEF     default width of the per-channel delay counter
//   MODE_NONRETRIG  retrig input value for non-retriggerable channels
//   MODE_RETRIG     retrig input value for retriggerable channels
package multi_one_shot_pkg;
   localparam int   COUNT_W_DEF    = 27;
   localparam logic MODE_NONRETRIG = 1'b0;
   localparam logic MODE_RETRIG    = 1'b1;
endpackage

// File: rtl/one_shot_chan.sv
// one_shot_chan: one digital one-shot channel with hold, retrigger and overrun.
//   clk, rst   clock and synchronous active-high reset
//   trig       trigger level, fires on a rising edge
//   hold_n     active-low, forces the pulse active and restarts it
//   retrig     MODE_RETRIG restarts on a busy trigger, else flags overrun
//   delay      pulse length in clk cycles, sampled only when loading
//   clr_ovr    clears the sticky overrun flag
//   q, q_n     pulse output and its complement
//   done       one-cycle strobe when a pulse ends naturally
//   overrun    sticky flag: trigger ignored while busy
module one_shot_chan
   import multi_one_shot_pkg::*;
#(
   parameter int COUNT_W = COUNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               trig,
   input  logic               hold_n,
   input  logic               retrig,
   input  logic [COUNT_W-1:0] delay,
   input  logic               clr_ovr,
   output logic               q,
   output logic               q_n,
   output logic               done,
   output logic               overrun
);
   logic [COUNT_W-1:0] count_q, count_d, dly_q, dly_d;
   logic               trig_d_q, ovr_q, ovr_d, done_q, done_d, edge_s, busy;

   assign edge_s = trig & ~trig_d_q;
   assign busy   = count_q != '0;

   always_comb begin
      count_d = count_q;
      dly_d   = dly_q;
      done_d  = 1'b0;
      // a new overrun in the same cycle overrides clr_ovr
      ovr_d   = ovr_q & ~clr_ovr;
      if (!hold_n) begin
         count_d = COUNT_W'(1);
         dly_d   = delay;
      end else if (edge_s && !busy) begin
         count_d = (delay != '0) ? COUNT_W'(1) : count_q;
         dly_d   = (delay != '0) ? delay : dly_q;
      end else if (edge_s && retrig == MODE_RETRIG) begin
         count_d = COUNT_W'(1);
         dly_d   = delay;
      end else begin
         ovr_d   = ovr_d | edge_s;
         count_d = !busy ? count_q : (count_q < dly_q) ? count_q + COUNT_W'(1) : '0;
         done_d  = busy && !(count_q < dly_q);
      end
   end

   // trig_d resets high so a trigger already high at reset release does not fire
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         dly_q    <= '0;
         trig_d_q <= 1'b1;
         ovr_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         dly_q    <= dly_d;
         trig_d_q <= trig;
         ovr_q    <= ovr_d;
         done_q   <= done_d;
      end
   end

   assign q       = busy;
   assign q_n     = ~busy;
   assign done    = done_q;
   assign overrun = ovr_q;
endmodule

// File: rtl/multi_one_shot.sv
// multi_one_shot: CHANNELS independent digital one-shots sharing one clock.
//   clk, rst   clock and synchronous active-high reset
//   trig       per-channel trigger level, fires on a rising edge
//   hold_n     per-channel active-low hold/restart
//   retrig     per-channel mode, 1 = retriggerable
//   delay      per-channel pulse length, channel i at [i*COUNT_W +: COUNT_W]
//   clr_ovr    per-channel overrun clear
//   q, q_n     per-channel pulse output and complement
//   done       per-channel end-of-pulse strobe
//   overrun    per-channel sticky overrun flag
module multi_one_shot
   import multi_one_shot_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int COUNT_W  = COUNT_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CHANNELS-1:0]         trig,
   input  logic [CHANNELS-1:0]         hold_n,
   input  logic [CHANNELS-1:0]         retrig,
   input  logic [CHANNELS*COUNT_W-1:0] delay,
   input  logic [CHANNELS-1:0]         clr_ovr,
   output logic [CHANNELS-1:0]         q,
   output logic [CHANNELS-1:0]         q_n,
   output logic [CHANNELS-1:0]         done,
   output logic [CHANNELS-1:0]         overrun
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      one_shot_chan #(.COUNT_W(COUNT_W)) u_chan (
         .clk     (clk),
         .rst     (rst),
         .trig    (trig[g]),
         .hold_n  (hold_n[g]),
         .retrig  (retrig[g]),
         .delay   (delay[g*COUNT_W +: COUNT_W]),
         .clr_ovr (clr_ovr[g]),
         .q       (q[g]),
         .q_n     (q_n[g]),
         .done    (done[g]),
         .overrun (overrun[g])
      );
   end
endmodule

// File: tb/tb_multi_one_shot.sv
// tb_multi_one_shot: scoreboard bench comparing the one-shots against a remaining-cycles model.
module tb_multi_one_shot;
   localparam int CH = 4;
   localparam int W  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [CH-1:0]   trig, hold_n, retrig, clr_ovr;
   logic [CH*W-1:0] delay;
   logic [CH-1:0]   q, q_n, done, overrun;

   typedef struct packed {
      logic [CH-1:0] q;
      logic [CH-1:0] done;
      logic [CH-1:0] ovr;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   stim_done = 0;

   int   rem[CH];
   bit   ovr_m[CH];
   bit   tprev[CH];

   multi_one_shot #(.CHANNELS(CH), .COUNT_W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .trig    (trig),
      .hold_n  (hold_n),
      .retrig  (retrig),
      .delay   (delay),
      .clr_ovr (clr_ovr),
      .q       (q),
      .q_n     (q_n),
      .done    (done),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   // Model: rem = number of clk cycles q still stays high; a load of d gives
   // d cycles (minimum one cycle when a forced load carries delay 0).
   task automatic model_step();
      exp_t e;
      e = '0;
      for (int i = 0; i < CH; i++) begin
         int  d;
         bit  ed;
         d  = int'(delay[i*W +: W]);
         ed = trig[i] && !tprev[i];
         if (rst) begin
            rem[i] = 0; ovr_m[i] = 0; tprev[i] = 1;
         end else begin
            tprev[i] = trig[i];
            if (clr_ovr[i]) ovr_m[i] = 0;
            if (!hold_n[i]) rem[i] = (d == 0) ? 1 : d;
            else if (ed && rem[i] == 0) begin
               if (d != 0) rem[i] = d;
            end else if (ed && retrig[i]) rem[i] = (d == 0) ? 1 : d;
            else begin
               if (ed) ovr_m[i] = 1;
               if (rem[i] > 0) begin
                  rem[i]--;
                  if (rem[i] == 0) e.done[i] = 1'b1;
               end
            end
         end
         e.q[i]   = rem[i] > 0;
         e.ovr[i] = ovr_m[i];
      end
      exp_q.push_back(e);
   endtask

   task automatic cyc(int n = 1);
      repeat (n) begin
         model_step();
         @(negedge clk);
      end
   endtask

   task automatic set_dly(int ch, int v);
      delay[ch*W +: W] = W'(v);
   endtask

   task automatic chk(string name, logic [CH-1:0] act, logic [CH-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("q", q, e.q);
         chk("q_n", q_n, ~e.q);
         chk("done", done, e.done);
         chk("overrun", overrun, e.ovr);
      end
   end

   initial begin
      rst = 1; trig = 4'b0001; hold_n = '1; retrig = '0; clr_ovr = '0; delay = '0;
      for (int i = 0; i < CH; i++) begin
         rem[i] = 0; ovr_m[i] = 0; tprev[i] = 1;
      end
      @(negedge clk);
      set_dly(0, 5);
      cyc(2);
      rst = 0; cyc(3);
      trig[0] = 0; cyc(1);
      trig[0] = 1; cyc(8);
      trig[0] = 0;
      retrig[1] = 1; set_dly(1, 10);
      trig[1] = 1; cyc(4);
      trig[1] = 0; cyc(1);
      trig[1] = 1; cyc(16);
      trig[1] = 0;
      retrig[2] = 0; set_dly(2, 10);
      trig[2] = 1; cyc(4);
      trig[2] = 0; cyc(1);
      trig[2] = 1; cyc(14);
      clr_ovr[2] = 1; cyc(1);
      clr_ovr[2] = 0; trig[2] = 0; cyc(2);
      set_dly(2, 4); trig[2] = 1; cyc(4);
      trig[2] = 0; cyc(1);
      trig[2] = 1; clr_ovr[2] = 1; cyc(1);
      clr_ovr[2] = 0; cyc(4);
      trig[2] = 0;
      set_dly(3, 3); hold_n[3] = 0; cyc(7);
      hold_n[3] = 1; cyc(6);
      set_dly(0, 0); trig[0] = 1; cyc(4);
      trig[0] = 0; set_dly(0, 8); cyc(1);
      trig[0] = 1; cyc(3);
      set_dly(0, 2); cyc(9);
      trig = '0; retrig = '0; cyc(1);
      for (int i = 0; i < CH; i++) set_dly(i, i + 1);
      trig = '1; cyc(6);
      trig = '0; set_dly(3, 9); cyc(1);
      trig = '1; cyc(3);
      rst = 1; cyc(1);
      rst = 0; cyc(3);
      repeat (3000) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 3) == 0) trig[i] = ~trig[i];
            hold_n[i]  = ($urandom_range(0, 15) != 0);
            clr_ovr[i] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) retrig[i] = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) set_dly(i, $urandom_range(0, 12));
         end
         rst = ($urandom_range(0, 199) == 0);
         cyc(1);
      end
      rst = 0; hold_n = '1; clr_ovr = '0;
      cyc(2);
      stim_done = 1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multi_one_shot.md
Name: multi_one_shot

Overview:
- Parametrised successor to the single-card integrating one-shot: CHANNELS independent digital one-shots in one block.
- Each channel has a per-channel runtime delay, a retriggerable or non-retriggerable mode, a hold/restart input, a completion strobe and a sticky overrun flag.
- Used wherever PDP-8/I timing cards need delays: memory timing, teletype and I/O pulse stretching. Runs on the 100 MHz system clock.

Parameters:
- CHANNELS, 2, number of independent one-shot channels (1..16).
- COUNT_W, 27, width of each channel's delay counter and delay value.

Ports:
- clk  in  1  100 MHz system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- trig  in  CHANNELS  per-channel trigger level; fires on a rising edge.
- hold_n  in  CHANNELS  active-low; forces the pulse active and restarts it.
- retrig  in  CHANNELS  1 = retriggerable, 0 = non-retriggerable.
- delay  in  CHANNELS*COUNT_W  per-channel pulse length in clk cycles; channel i uses bits [i*COUNT_W +: COUNT_W].
- clr_ovr  in  CHANNELS  clears the matching overrun flag.
- q  out  CHANNELS  pulse output, active high.
- q_n  out  CHANNELS  complement of q.
- done  out  CHANNELS  one-cycle strobe when a pulse ends naturally.
- overrun  out  CHANNELS  sticky; trigger ignored while busy in non-retrig mode.

Behaviour (per channel; channels are fully independent):
- State per channel:
  - count[COUNT_W-1:0]; 0 = idle, 1..dly = active.
  - dly, the latched delay.
  - trig_d, the previous trig sample.
  - ovr, the overrun flag.
- Reset (rst=1 at a clk edge): count=0, dly=0, ovr=0, trig_d=1.
  - trig_d=1 means a trig already high when reset releases does not fire.
  - After reset: q=0, q_n=1, done=0, overrun=0.
- Edge detect: edge = trig & ~trig_d. trig_d <= trig every non-reset cycle.
- Priority at each edge, highest first:
  1. rst.
  2. hold_n=0: count<=1, dly<=delay. Trigger is ignored; this is not an overrun.
  3. edge with count==0 and delay!=0: count<=1, dly<=delay.
  4. edge with count!=0:
     - retrig=1: count<=1, dly<=delay (restart).
     - retrig=0: no restart; ovr<=1.
  5. count!=0 and count<dly: count<=count+1.
  6. count!=0 and count>=dly: count<=0, done asserted for that one cycle.
- Latency: trig rises at edge N (sampled) → q=1 after edge N, i.e. registered, 1 cycle.
- Pulse width: q is high for exactly dly clk cycles.
- delay=0 at trigger: no pulse, no done, no overrun.
- delay is sampled only at load. Changing delay mid-pulse has no effect until the next load.
- hold_n release: q stays high for exactly dly cycles after the last edge at which hold_n was sampled low, then done pulses.
- Retrigger restarts the pulse and does not strobe done. done fires only on the count>=dly → 0 transition.
- done is registered: high in the cycle after the edge where count became 0; that is also the first cycle in which q=0.
- Edge coinciding with the terminal cycle (count==dly): this is treated as count!=0.
  - retrig=1: restart, no done.
  - retrig=0: ovr set, pulse ends, done asserted.
- clr_ovr=1 clears ovr. If clr_ovr and a new overrun occur in the same cycle, set wins.
- Outputs: q = (count!=0), q_n = ~q, both combinational from the registers. done and overrun are registers.
- A trig held high produces one pulse only; no free-running.
- rst mid-pulse: pulse ends immediately after the edge, with no done.

Decomposition:
- Package multi_one_shot_pkg: default COUNT_W localparam, MODE_NONRETRIG=0 / MODE_RETRIG=1 constants.
- One sub-module, one_shot_chan, holds the single-channel state and logic. It is instantiated CHANNELS times with generate and slices delay per channel.

Test Plan:
- Reset release with trig[0]=1, delay=5 → no pulse. Then trig 0→1 → q[0] high for exactly 5 cycles starting 1 cycle later, done[0] for 1 cycle at the fall.
- retrig=1, delay=10, second edge 4 cycles into pulse → q high for 14 cycles total, done once.
- retrig=0, delay=10, second edge at cycle 4 → q high 10 cycles, overrun=1 and stays 1. clr_ovr pulse → overrun=0.
- hold_n=0 for 7 cycles, delay=3 → q high throughout and for 3 cycles after release, no overrun, done once.
- delay=0 trigger → q stays 0, no done. Change delay 8→2 mid-pulse → pulse still 8 cycles.
- CHANNELS=4, simultaneous triggers with delays 1/2/3/4 → independent widths 1/2/3/4; rst mid-pulse → all q=0 next cycle, no done.
